// File: rtl/path_pkg.sv
// Shared types and defaults for the path sequencer: move encoding, FSM states,
// default CPU store addresses and the move-to-enable decode.
package path_pkg;

    typedef enum logic [1:0] {
        FWD   = 2'b00,
        RIGHT = 2'b01,
        LEFT  = 2'b10,
        REV   = 2'b11
    } dir_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        DONE
    } state_t;

    localparam logic [31:0] DEF_PATH_BASE = 32'h0000_0400;
    localparam logic [31:0] DEF_LEN_ADDR  = 32'h0000_03FC;

    // Enable vector ordering is {reverse, left, right, forward}.
    function automatic logic [3:0] dir_onehot(input dir_t d);
        return 4'b0001 << d;
    endfunction

endpackage

// File: rtl/path_ram.sv
// Path buffer: DEPTH entries of {dir, node}, one synchronous write port and
// two combinational read ports (current entry and the one after it).
module path_ram #(
    parameter int NODE_W = 5,
    parameter int DEPTH  = 32,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [AW-1:0]     i_waddr,
    input  logic [NODE_W+1:0] i_wdata,
    input  logic [AW-1:0]     i_raddr0,
    output logic [NODE_W+1:0] o_rdata0,
    input  logic [AW-1:0]     i_raddr1,
    output logic [NODE_W+1:0] o_rdata1
);

    logic [NODE_W+1:0] r_mem [DEPTH];

    // Contents are don't-care after reset, so no reset on the array.
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata0 = r_mem[i_raddr0];
    assign o_rdata1 = r_mem[i_raddr1];

endmodule

// File: rtl/path_sequencer.sv
// Captures a {dir, node} path written by the CPU, then walks it one entry per
// node_update rising edge, driving present/past/future nodes and turn enables.
module path_sequencer
    import path_pkg::*;
#(
    parameter int          NODE_W    = 5,
    parameter int          DEPTH     = 32,
    parameter logic [31:0] PATH_BASE = DEF_PATH_BASE,
    parameter logic [31:0] LEN_ADDR  = DEF_LEN_ADDR,
    parameter int          IW        = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemWrite,
    input  logic [31:0]       DataAdr,
    input  logic [31:0]       WriteData,
    input  logic              node_update,
    input  logic              flush,
    output logic              cpu_done,
    output logic              arrived,
    output logic              len_err,
    output logic              forward_en,
    output logic              right_en,
    output logic              left_en,
    output logic              reverse_en,
    output logic              prev_forward_en,
    output logic              prev_right_en,
    output logic              prev_left_en,
    output logic              prev_reverse_en,
    output logic [NODE_W-1:0] present_node,
    output logic [NODE_W-1:0] past_node,
    output logic [NODE_W-1:0] future_node,
    output logic [IW-1:0]     path_len,
    output logic [IW-1:0]     path_idx
);

    localparam int          AW        = $clog2(DEPTH);
    localparam logic [31:0] WIN_BYTES = 32'(4 * DEPTH);

    state_t            r_state, w_state_nxt;
    logic              r_nu_d;
    logic [IW-1:0]     r_len, r_idx, w_len_nxt, w_idx_nxt;
    logic [NODE_W-1:0] r_present, r_past, r_future;
    logic [NODE_W-1:0] w_present_nxt, w_past_nxt, w_future_nxt;
    logic [3:0]        r_en, r_prev, w_en_nxt, w_prev_nxt;
    logic              r_cpu_done, r_arrived, r_len_err;
    logic              w_cpu_done_nxt, w_arrived_nxt, w_len_err_nxt;

    // Store decode
    logic [31:0]       w_off;
    logic              w_path_wr, w_commit, w_edge, w_len_bad, w_we, w_load, w_last;
    logic [7:0]        w_L;
    logic [IW-1:0]     w_base, w_len_cmp;
    logic [AW-1:0]     w_ra0, w_ra1;
    logic [NODE_W+1:0] w_e0, w_e1;
    logic              w_unused;

    assign w_off     = DataAdr - PATH_BASE;
    assign w_path_wr = MemWrite && (DataAdr[1:0] == 2'b00) &&
                       (DataAdr >= PATH_BASE) && (w_off < WIN_BYTES);
    assign w_commit  = MemWrite && (DataAdr == LEN_ADDR);
    assign w_edge    = node_update && !r_nu_d;
    assign w_L       = WriteData[7:0];
    assign w_len_bad = (w_L == 8'd0) || (int'(w_L) > DEPTH);
    assign w_we      = w_path_wr && !flush && !reset && (r_state != RUN);

    // Entry about to become "present": 0 on commit, idx+1 on a step.
    assign w_base    = (r_state == RUN) ? r_idx + IW'(1) : '0;
    assign w_ra0     = w_base[AW-1:0];
    assign w_ra1     = w_ra0 + AW'(1);
    assign w_len_cmp = (r_state == LOAD) ? IW'(w_L) : r_len;
    assign w_last    = (w_base + IW'(1)) == w_len_cmp;

    assign w_unused  = ^{WriteData[31:8], w_e0[NODE_W+1:NODE_W]};

    path_ram #(
        .NODE_W (NODE_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk      (clk),
        .i_we     (w_we),
        .i_waddr  (w_off[AW+1:2]),
        .i_wdata  (WriteData[NODE_W+1:0]),
        .i_raddr0 (w_ra0),
        .o_rdata0 (w_e0),
        .i_raddr1 (w_ra1),
        .o_rdata1 (w_e1)
    );

    always_comb begin
        w_state_nxt    = r_state;
        w_len_nxt      = r_len;
        w_idx_nxt      = r_idx;
        w_present_nxt  = r_present;
        w_past_nxt     = r_past;
        w_future_nxt   = r_future;
        w_en_nxt       = r_en;
        w_prev_nxt     = r_prev;
        w_cpu_done_nxt = r_cpu_done;
        w_arrived_nxt  = 1'b0;
        w_len_err_nxt  = r_len_err;
        w_load         = 1'b0;

        if (flush) begin
            w_state_nxt    = IDLE;
            w_en_nxt       = '0;
            w_prev_nxt     = '0;
            w_cpu_done_nxt = 1'b0;
            w_len_err_nxt  = 1'b0;
        end else begin
            case (r_state)
                IDLE: if (w_path_wr) w_state_nxt = LOAD;
                LOAD: if (w_commit) begin
                    if (w_len_bad) begin
                        w_len_err_nxt = 1'b1;
                        w_state_nxt   = IDLE;
                    end else begin
                        w_len_nxt = IW'(w_L);
                        w_idx_nxt = '0;
                        w_load    = 1'b1;
                    end
                end
                RUN: if (w_edge) begin
                    w_past_nxt = r_present;
                    w_prev_nxt = r_en;
                    w_idx_nxt  = w_base;
                    w_load     = 1'b1;
                end
                DONE: if (w_path_wr) begin
                    w_state_nxt = LOAD;
                    w_len_nxt   = '0;
                    w_idx_nxt   = '0;
                end
                default: w_state_nxt = IDLE;
            endcase
        end

        // Shared by commit and step: present from entry[base], look ahead one.
        if (w_load) begin
            w_present_nxt = w_e0[NODE_W-1:0];
            if (w_last) begin
                w_future_nxt   = w_e0[NODE_W-1:0];
                w_en_nxt       = '0;
                w_arrived_nxt  = 1'b1;
                w_cpu_done_nxt = 1'b0;
                w_state_nxt    = DONE;
            end else begin
                w_future_nxt   = w_e1[NODE_W-1:0];
                w_en_nxt       = dir_onehot(dir_t'(w_e1[NODE_W+1:NODE_W]));
                w_cpu_done_nxt = 1'b1;
                w_state_nxt    = RUN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_nu_d     <= 1'b0;
            r_len      <= '0;
            r_idx      <= '0;
            r_present  <= '0;
            r_past     <= '0;
            r_future   <= '0;
            r_en       <= '0;
            r_prev     <= '0;
            r_cpu_done <= 1'b0;
            r_arrived  <= 1'b0;
            r_len_err  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_nu_d     <= node_update;
            r_len      <= w_len_nxt;
            r_idx      <= w_idx_nxt;
            r_present  <= w_present_nxt;
            r_past     <= w_past_nxt;
            r_future   <= w_future_nxt;
            r_en       <= w_en_nxt;
            r_prev     <= w_prev_nxt;
            r_cpu_done <= w_cpu_done_nxt;
            r_arrived  <= w_arrived_nxt;
            r_len_err  <= w_len_err_nxt;
        end
    end

    assign cpu_done        = r_cpu_done;
    assign arrived         = r_arrived;
    assign len_err         = r_len_err;
    assign forward_en      = r_en[0];
    assign right_en        = r_en[1];
    assign left_en         = r_en[2];
    assign reverse_en      = r_en[3];
    assign prev_forward_en = r_prev[0];
    assign prev_right_en   = r_prev[1];
    assign prev_left_en    = r_prev[2];
    assign prev_reverse_en = r_prev[3];
    assign present_node    = r_present;
    assign past_node       = r_past;
    assign future_node     = r_future;
    assign path_len        = r_len;
    assign path_idx        = r_idx;

endmodule

// File: tb/tb_path_sequencer.sv
// Bench for path_sequencer: directed scenarios with literal expectations, then
// randomized stores/steps/flushes compared every cycle against a path model.
module tb_path_sequencer;

    localparam int          NODE_W = 5;
    localparam int          DEPTH  = 32;
    localparam int          IW     = 6;
    localparam logic [31:0] BASE   = 32'h0000_0400;
    localparam logic [31:0] LENA   = 32'h0000_03FC;
    localparam int S_IDLE = 0, S_LOAD = 1, S_RUN = 2, S_DONE = 3;

    logic clk = 1'b0;
    logic reset, MemWrite, node_update, flush;
    logic [31:0] DataAdr, WriteData;
    logic cpu_done, arrived, len_err;
    logic forward_en, right_en, left_en, reverse_en;
    logic prev_forward_en, prev_right_en, prev_left_en, prev_reverse_en;
    logic [NODE_W-1:0] present_node, past_node, future_node;
    logic [IW-1:0] path_len, path_idx;

    int checks = 0;
    int errors = 0;
    int arr_cnt = 0;

    path_sequencer dut (
        .clk(clk), .reset(reset), .MemWrite(MemWrite), .DataAdr(DataAdr),
        .WriteData(WriteData), .node_update(node_update), .flush(flush),
        .cpu_done(cpu_done), .arrived(arrived), .len_err(len_err),
        .forward_en(forward_en), .right_en(right_en), .left_en(left_en),
        .reverse_en(reverse_en), .prev_forward_en(prev_forward_en),
        .prev_right_en(prev_right_en), .prev_left_en(prev_left_en),
        .prev_reverse_en(prev_reverse_en), .present_node(present_node),
        .past_node(past_node), .future_node(future_node),
        .path_len(path_len), .path_idx(path_idx)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    int p_node [DEPTH];
    int p_dir  [DEPTH];
    int m_mode = S_IDLE, m_len = 0, m_idx = 0;
    int m_present = 0, m_past = 0, m_future = 0, m_en = 0, m_prev = 0;
    int m_cpu = 0, m_arr = 0, m_err = 0, m_nu_prev = 0;
    bit started = 0;

    task automatic m_place();
        m_present = p_node[m_idx];
        if (m_idx == m_len - 1) begin
            m_future = m_present; m_en = 0; m_arr = 1; m_cpu = 0; m_mode = S_DONE;
        end else begin
            m_future = p_node[m_idx + 1]; m_en = 1 << p_dir[m_idx + 1];
            m_cpu = 1; m_mode = S_RUN;
        end
    endtask

    initial forever begin
        longint a;
        bit pw, cm, edg;
        int k, L;
        @(posedge clk);
        if (reset) begin
            started = 1;
            m_mode = S_IDLE; m_len = 0; m_idx = 0; m_present = 0; m_past = 0;
            m_future = 0; m_en = 0; m_prev = 0; m_cpu = 0; m_arr = 0; m_err = 0;
            m_nu_prev = 0;
        end else begin
            a   = longint'(DataAdr);
            pw  = MemWrite && (a % 4 == 0) && a >= longint'(BASE) &&
                  a < longint'(BASE) + 4 * DEPTH;
            cm  = MemWrite && (DataAdr == LENA);
            edg = node_update && (m_nu_prev == 0);
            m_nu_prev = int'(node_update);
            m_arr = 0;
            if (flush) begin
                m_mode = S_IDLE; m_en = 0; m_prev = 0; m_cpu = 0; m_err = 0;
            end else if (m_mode == S_RUN && edg) begin
                m_past = m_present; m_prev = m_en; m_idx = m_idx + 1;
                m_place();
            end else if (m_mode == S_LOAD && cm) begin
                L = int'(WriteData[7:0]);
                if (L == 0 || L > DEPTH) begin
                    m_err = 1; m_mode = S_IDLE;
                end else begin
                    m_len = L; m_idx = 0;
                    m_place();
                end
            end else if (m_mode != S_RUN && pw) begin
                k = int'((a - longint'(BASE)) / 4);
                p_node[k] = int'(WriteData[NODE_W-1:0]);
                p_dir[k]  = int'(WriteData[NODE_W+1:NODE_W]);
                if (m_mode == S_DONE) begin m_len = 0; m_idx = 0; end
                m_mode = S_LOAD;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial forever begin
        logic [37:0] act, exp;
        @(negedge clk);
        if (arrived) arr_cnt++;
        if (started) begin
            act = {cpu_done, arrived, len_err,
                   reverse_en, left_en, right_en, forward_en,
                   prev_reverse_en, prev_left_en, prev_right_en, prev_forward_en,
                   present_node, past_node, future_node, path_len, path_idx};
            exp = {m_cpu[0], m_arr[0], m_err[0], m_en[3:0], m_prev[3:0],
                   m_present[NODE_W-1:0], m_past[NODE_W-1:0], m_future[NODE_W-1:0],
                   m_len[IW-1:0], m_idx[IW-1:0]};
            checks++;
            if (act !== exp) begin
                errors++;
                if (errors < 20)
                    $display("FAIL model_cmp t=%0t got %h want %h", $time, act, exp);
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] ent(input int d, input int n);
        return 32'((d << NODE_W) | n);
    endfunction

    task automatic st(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk); MemWrite = 1'b1; DataAdr = a; WriteData = d;
        @(negedge clk); MemWrite = 1'b0;
    endtask

    task automatic nu_edge();
        @(negedge clk); node_update = 1'b1;
        @(negedge clk); node_update = 1'b0;
    endtask

    task automatic pulse_flush();
        @(negedge clk); flush = 1'b1;
        @(negedge clk); flush = 1'b0;
    endtask

    function automatic int en4();
        return int'({reverse_en, left_en, right_en, forward_en});
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int a0;
        logic [31:0] tmp;
        int r;
        reset = 1'b1; MemWrite = 1'b0; flush = 1'b0; node_update = 1'b0;
        DataAdr = '0; WriteData = '0;
        repeat (3) @(negedge clk);
        chk("rst_cpu_done", int'(cpu_done), 0);
        chk("rst_present", int'(present_node), 0);
        chk("rst_len", int'(path_len), 0);
        reset = 1'b0;

        // Main walk: 3 -> 4 (fwd) -> 9 (right) -> 12 (left)
        st(BASE, 32'd3); st(BASE + 4, ent(0, 4)); st(BASE + 8, ent(1, 9));
        st(BASE + 12, ent(2, 12)); st(LENA, 32'd4);
        chk("commit_cpu_done", int'(cpu_done), 1);
        chk("commit_present", int'(present_node), 3);
        chk("commit_future", int'(future_node), 4);
        chk("commit_fwd_en", int'(forward_en), 1);
        a0 = arr_cnt;
        nu_edge();
        chk("step1_present", int'(present_node), 4);
        chk("step1_future", int'(future_node), 9);
        chk("step1_right_en", int'(right_en), 1);
        chk("step1_prev_fwd", int'(prev_forward_en), 1);
        nu_edge();
        chk("step2_present", int'(present_node), 9);
        chk("step2_left_en", int'(left_en), 1);
        nu_edge();
        chk("step3_present", int'(present_node), 12);
        chk("step3_future", int'(future_node), 12);
        chk("step3_en_zero", en4(), 0);
        chk("step3_past", int'(past_node), 9);
        chk("step3_prev_left", int'(prev_left_en), 1);
        chk("step3_arrived", int'(arrived), 1);
        repeat (3) @(negedge clk);
        chk("arrived_once", arr_cnt - a0, 1);

        // Held-high node_update gives one step only
        st(BASE, 32'd3);
        chk("done_write_clears_len", int'(path_len), 0);
        st(LENA, 32'd4);
        @(negedge clk); node_update = 1'b1;
        repeat (10) @(negedge clk);
        node_update = 1'b0;
        @(negedge clk);
        chk("hold_idx", int'(path_idx), 1);
        chk("hold_cpu_done", int'(cpu_done), 1);

        // Store in RUN ignored; flush beats a simultaneous edge
        st(BASE, 32'd20);
        chk("run_store_present", int'(present_node), 4);
        @(negedge clk); flush = 1'b1; node_update = 1'b1;
        @(negedge clk); flush = 1'b0; node_update = 1'b0;
        chk("flush_cpu_done", int'(cpu_done), 0);
        chk("flush_idx", int'(path_idx), 1);
        chk("flush_en", en4(), 0);
        st(BASE + 4, ent(0, 4)); st(LENA, 32'd2);
        chk("entry0_kept", int'(present_node), 3);
        pulse_flush();

        // Bad lengths
        st(BASE, 32'd3); st(LENA, 32'd0);
        chk("len0_err", int'(len_err), 1);
        chk("len0_cpu_done", int'(cpu_done), 0);
        st(BASE, 32'd3); st(LENA, 32'(DEPTH + 1));
        chk("lenbig_err", int'(len_err), 1);
        chk("lenbig_cpu_done", int'(cpu_done), 0);
        pulse_flush();
        chk("flush_clears_err", int'(len_err), 0);

        // Single-node path
        st(BASE, 32'd7); st(LENA, 32'd1);
        chk("l1_arrived", int'(arrived), 1);
        chk("l1_present", int'(present_node), 7);
        chk("l1_future", int'(future_node), 7);
        chk("l1_en", en4(), 0);
        pulse_flush();

        // Unaligned / out-of-window stores leave IDLE, so commit is ignored
        st(BASE + 2, 32'd5); st(BASE + 32'(4 * DEPTH), 32'd5); st(LENA, 32'd2);
        chk("badwr_cpu_done", int'(cpu_done), 0);
        chk("badwr_len", int'(path_len), 1);

        // Reset mid-RUN
        st(BASE, 32'd3); st(LENA, 32'd4); nu_edge();
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        chk("rstrun_present", int'(present_node), 0);
        chk("rstrun_past", int'(past_node), 0);
        chk("rstrun_cpu_done", int'(cpu_done), 0);
        chk("rstrun_idx", int'(path_idx), 0);

        // Random phase: fill the whole buffer so model and RAM agree everywhere
        for (int k = 0; k < DEPTH; k++) st(BASE + 32'(4 * k), $urandom);
        pulse_flush();
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            reset = ($urandom_range(0, 199) == 0);
            flush = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 99) < 15) node_update = ~node_update;
            MemWrite = ($urandom_range(0, 3) == 0);
            r = int'($urandom_range(0, 9));
            if (r <= 5) begin
                DataAdr = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
                WriteData = $urandom;
            end else if (r <= 7) begin
                tmp = $urandom;
                if ($urandom_range(0, 3) == 0) tmp[7:0] = 8'($urandom_range(0, DEPTH + 2));
                else tmp[7:0] = 8'($urandom_range(1, 6));
                DataAdr = LENA; WriteData = tmp;
            end else if (r == 8) begin
                DataAdr = BASE + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(1, 3));
                WriteData = $urandom;
            end else begin
                DataAdr = BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 7));
                WriteData = $urandom;
            end
        end
        @(negedge clk);
        reset = 1'b0; flush = 1'b0; MemWrite = 1'b0; node_update = 1'b0;
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
